// File: rtl/axis_tg_pkg.sv
// Shared definitions for the multi-channel AXI-Stream traffic generator:
// pattern mode encodings, LFSR constants, channel FSM states and the
// pattern helper functions used by every channel.
package axis_tg_pkg;

    localparam logic [1:0] MODE_COUNT = 2'd0;
    localparam logic [1:0] MODE_LFSR  = 2'd1;
    localparam logic [1:0] MODE_CONST = 2'd2;

    // Galois feedback mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
    localparam logic [31:0] LFSR_POLY      = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED_BASE = 32'hACE1_0000;
    localparam logic [31:0] CONST_BASE     = 32'hA5A5_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } tg_state_e;

    // One Galois LFSR step: shift right, fold the polynomial in when bit 0 falls out.
    function automatic logic [31:0] lfsr_next(input logic [31:0] state);
        return state[0] ? ({1'b0, state[31:1]} ^ LFSR_POLY) : {1'b0, state[31:1]};
    endfunction

    // Low 32-bit word of a beat for the selected pattern; reserved mode acts as count.
    function automatic logic [31:0] pattern_word(
        input logic [1:0]  mode,
        input logic [7:0]  ch,
        input logic [7:0]  pkt,
        input logic [15:0] beat,
        input logic [31:0] lfsr
    );
        logic [31:0] word;
        case (mode)
            MODE_LFSR:  word = lfsr;
            MODE_CONST: word = CONST_BASE | {24'h00_0000, ch};
            default:    word = {ch, pkt, beat};
        endcase
        return word;
    endfunction

endpackage

// File: rtl/axis_tg_channel.sv
// One AXI-Stream master channel: IDLE/SEND/GAP/DONE sequencer with a
// count / LFSR / constant pattern source. All outputs are registered so the
// next beat is prepared on the same edge that accepts the current one.
module axis_tg_channel
    import axis_tg_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int PKT_LEN    = 16,
    parameter int NUM_PKTS   = 8,
    parameter int CH_ID      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [7:0]            gap,
    output logic [DATA_WIDTH-1:0] tdata,
    output logic                  tvalid,
    output logic                  tlast,
    input  logic                  tready,
    output logic                  done,
    output logic                  active
);

    localparam int          LANES     = DATA_WIDTH / 32;
    localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);
    localparam logic [7:0]  LAST_PKT  = 8'(NUM_PKTS - 1);
    localparam logic [7:0]  CH        = 8'(CH_ID);
    localparam logic [31:0] SEED      = LFSR_SEED_BASE | {24'h00_0000, CH};
    localparam logic        ONE_BEAT  = (LAST_BEAT == 16'd0);

    tg_state_e              state_r;
    logic [1:0]             mode_r;
    logic [7:0]             gap_r;
    logic [7:0]             gap_cnt_r;
    logic [7:0]             pkt_idx_r;
    logic [15:0]            beat_idx_r;
    logic [31:0]            lfsr_r;
    logic [DATA_WIDTH-1:0]  tdata_r;
    logic                   tvalid_r;
    logic                   tlast_r;
    logic                   done_r;
    logic                   active_r;

    logic                   accept_s;
    logic                   last_beat_s;
    logic [31:0]            lfsr_adv_s;

    // Replicate a 32-bit pattern word across every lane of the beat.
    function automatic logic [DATA_WIDTH-1:0] replicate(input logic [31:0] word);
        return {LANES{word}};
    endfunction

    assign accept_s    = tvalid_r & tready;
    assign last_beat_s = (beat_idx_r == LAST_BEAT);
    assign lfsr_adv_s  = lfsr_next(lfsr_r);

    // Channel sequencer: state, counters, LFSR and registered AXIS/status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            mode_r     <= MODE_COUNT;
            gap_r      <= 8'd0;
            gap_cnt_r  <= 8'd0;
            pkt_idx_r  <= 8'd0;
            beat_idx_r <= 16'd0;
            lfsr_r     <= SEED;
            tdata_r    <= '0;
            tvalid_r   <= 1'b0;
            tlast_r    <= 1'b0;
            done_r     <= 1'b0;
            active_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_r    <= ST_SEND;
                        mode_r     <= mode;
                        gap_r      <= gap;
                        gap_cnt_r  <= 8'd0;
                        pkt_idx_r  <= 8'd0;
                        beat_idx_r <= 16'd0;
                        lfsr_r     <= SEED;
                        done_r     <= 1'b0;
                        active_r   <= 1'b1;
                        tvalid_r   <= 1'b1;
                        tlast_r    <= ONE_BEAT;
                        tdata_r    <= replicate(pattern_word(mode, CH, 8'd0, 16'd0, SEED));
                    end
                end
                ST_SEND: begin
                    if (accept_s) begin
                        // LFSR moves only on an accepted beat, so stalls never skip values
                        lfsr_r <= lfsr_adv_s;
                        if (last_beat_s) begin
                            pkt_idx_r  <= pkt_idx_r + 8'd1;
                            beat_idx_r <= 16'd0;
                            if (pkt_idx_r == LAST_PKT) begin
                                state_r  <= ST_DONE;
                                tvalid_r <= 1'b0;
                                tlast_r  <= 1'b0;
                                tdata_r  <= '0;
                                done_r   <= 1'b1;
                                active_r <= 1'b0;
                            end else if (gap_r != 8'd0) begin
                                state_r   <= ST_GAP;
                                gap_cnt_r <= gap_r;
                                tvalid_r  <= 1'b0;
                                tlast_r   <= 1'b0;
                                tdata_r   <= '0;
                            end else begin
                                // back-to-back: first beat of the next packet, no bubble
                                tlast_r <= ONE_BEAT;
                                tdata_r <= replicate(pattern_word(mode_r, CH, pkt_idx_r + 8'd1,
                                                                  16'd0, lfsr_adv_s));
                            end
                        end else begin
                            beat_idx_r <= beat_idx_r + 16'd1;
                            tlast_r    <= ((beat_idx_r + 16'd1) == LAST_BEAT);
                            tdata_r    <= replicate(pattern_word(mode_r, CH, pkt_idx_r,
                                                                 beat_idx_r + 16'd1, lfsr_adv_s));
                        end
                    end
                end
                ST_GAP: begin
                    // counter holds the idle cycles still to spend; the last one reloads the beat
                    if (gap_cnt_r <= 8'd1) begin
                        state_r   <= ST_SEND;
                        gap_cnt_r <= 8'd0;
                        tvalid_r  <= 1'b1;
                        tlast_r   <= ONE_BEAT;
                        tdata_r   <= replicate(pattern_word(mode_r, CH, pkt_idx_r, 16'd0, lfsr_r));
                    end else begin
                        gap_cnt_r <= gap_cnt_r - 8'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign tdata  = tdata_r;
    assign tvalid = tvalid_r;
    assign tlast  = tlast_r;
    assign done   = done_r;
    assign active = active_r;

endmodule

// File: rtl/axis_traffic_gen_mc.sv
// Multi-channel AXI-Stream traffic generator: NUM_CH independent channels
// launched by one start pulse, with per-channel and global completion flags.
module axis_traffic_gen_mc
    import axis_tg_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_CH     = 4,
    parameter int PKT_LEN    = 16,
    parameter int NUM_PKTS   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [1:0]                   mode,
    input  logic [7:0]                   gap,
    output logic [NUM_CH*DATA_WIDTH-1:0] axis_tdata,
    output logic [NUM_CH-1:0]            axis_tvalid,
    output logic [NUM_CH-1:0]            axis_tlast,
    input  logic [NUM_CH-1:0]            axis_tready,
    output logic [NUM_CH-1:0]            ch_done,
    output logic                         all_done,
    output logic                         busy
);

    logic [NUM_CH-1:0] active_s;
    logic              start_ok_s;

    // A start only launches a run when no channel is sending or gapping; this
    // also rejects a start that coincides with the final acceptance.
    assign start_ok_s = start & ~busy;
    assign busy       = |active_s;
    assign all_done   = &ch_done;

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            axis_tg_channel #(
                .DATA_WIDTH (DATA_WIDTH),
                .PKT_LEN    (PKT_LEN),
                .NUM_PKTS   (NUM_PKTS),
                .CH_ID      (c)
            ) u_ch (
                .clk    (clk),
                .rst    (rst),
                .start  (start_ok_s),
                .mode   (mode),
                .gap    (gap),
                .tdata  (axis_tdata[c*DATA_WIDTH +: DATA_WIDTH]),
                .tvalid (axis_tvalid[c]),
                .tlast  (axis_tlast[c]),
                .tready (axis_tready[c]),
                .done   (ch_done[c]),
                .active (active_s[c])
            );
        end
    endgenerate

endmodule

// File: tb/tb_axis_traffic_gen_mc.sv
// Directed bench for axis_traffic_gen_mc with default parameters
// (64-bit beats, 4 channels, 16-beat packets, 8 packets per run).
module tb_axis_traffic_gen_mc;

    localparam int DW  = 64;
    localparam int NCH = 4;

    logic              clk   = 1'b0;
    logic              rst   = 1'b0;
    logic              start = 1'b0;
    logic [1:0]        mode  = 2'd0;
    logic [7:0]        gap   = 8'd0;
    logic [NCH*DW-1:0] axis_tdata;
    logic [NCH-1:0]    axis_tvalid;
    logic [NCH-1:0]    axis_tlast;
    logic [NCH-1:0]    axis_tready = '1;
    logic [NCH-1:0]    ch_done;
    logic              all_done;
    logic              busy;

    int          n_cmp = 0;
    int          n_err = 0;
    int          acc;
    logic        fin;
    logic [31:0] ref_s;

    always #5 clk = ~clk;

    axis_traffic_gen_mc dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mode        (mode),
        .gap         (gap),
        .axis_tdata  (axis_tdata),
        .axis_tvalid (axis_tvalid),
        .axis_tlast  (axis_tlast),
        .axis_tready (axis_tready),
        .ch_done     (ch_done),
        .all_done    (all_done),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] word(input int c);
        return axis_tdata[c*DW +: DW];
    endfunction

    function automatic logic [63:0] cnt_word(input logic [7:0] c, input logic [7:0] p,
                                             input logic [15:0] b);
        return {c, p, b, c, p, b};
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        // ---------------- reset state ----------------
        #3;
        chk("rst_tvalid", 64'(axis_tvalid), 64'h0);
        chk("rst_tlast", 64'(axis_tlast), 64'h0);
        for (int c = 0; c < NCH; c++) chk("rst_tdata", word(c), 64'h0);
        chk("rst_ch_done", 64'(ch_done), 64'h0);
        chk("rst_all_done", 64'(all_done), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        #10 rst = 1'b1;
        step();
        step();
        chk("idle_tvalid", 64'(axis_tvalid), 64'h0);

        // ---------------- 1: count pattern, no gap, full throughput ----------------
        mode = 2'd0;
        gap  = 8'd0;
        pulse_start();
        for (int b = 0; b < 128; b++) begin
            chk("t1_valid", 64'(axis_tvalid), 64'hF);
            chk("t1_data", word(2), cnt_word(8'h02, 8'(b / 16), 16'(b % 16)));
            chk("t1_last", 64'(axis_tlast[2]), 64'((b % 16) == 15));
            if (b == 0)   chk("t1_beat0", word(2), 64'h0200_0000_0200_0000);
            if (b == 17)  chk("t1_beat17", word(2), 64'h0201_0001_0201_0001);
            if (b == 127) chk("t1_alldone_early", 64'(all_done), 64'h0);
            step();
        end
        chk("t1_all_done", 64'(all_done), 64'h1);
        chk("t1_ch_done", 64'(ch_done), 64'hF);
        chk("t1_busy", 64'(busy), 64'h0);
        chk("t1_idle_valid", 64'(axis_tvalid), 64'h0);

        // ---------------- 2: backpressure on channel 0 ----------------
        pulse_start();
        acc = 0;
        fin = 1'b0;
        for (int s = 0; s < 300 && !fin; s++) begin
            if (acc == 128) begin
                chk("t2_ch0_done", 64'(ch_done[0]), 64'h1);
                chk("t2_all_done", 64'(all_done), 64'h1);
                chk("t2_ch0_cycles", 64'(s), 64'd255);
                fin = 1'b1;
            end else begin
                if (s == 0)   chk("t2_done_cleared", 64'(ch_done), 64'h0);
                if (s == 128) chk("t2_others_done", 64'(ch_done), 64'hE);
                chk("t2_valid0", 64'(axis_tvalid[0]), 64'h1);
                chk("t2_data0", word(0), cnt_word(8'h00, 8'(acc / 16), 16'(acc % 16)));
                chk("t2_last0", 64'(axis_tlast[0]), 64'((acc % 16) == 15));
                axis_tready[0] = (s % 2 == 0);
                if (axis_tvalid[0] && axis_tready[0]) acc++;
                step();
            end
        end
        chk("t2_finished", 64'(fin), 64'h1);
        axis_tready = '1;

        // ---------------- 3: constant pattern with 3-cycle gap ----------------
        mode = 2'd2;
        gap  = 8'd3;
        pulse_start();
        mode = 2'd0;
        gap  = 8'd0;
        for (int s = 0; s < 149; s++) begin
            chk("t3_valid1", 64'(axis_tvalid[1]), 64'((s % 19) < 16));
            if ((s % 19) < 16) begin
                chk("t3_data1", word(1), 64'hA5A5_0001_A5A5_0001);
                chk("t3_last1", 64'(axis_tlast[1]), 64'((s % 19) == 15));
            end
            step();
        end
        chk("t3_ch_done", 64'(ch_done), 64'hF);
        chk("t3_all_done", 64'(all_done), 64'h1);

        // ---------------- 4: LFSR pattern, random ready, rerun reproduces ----------------
        for (int r = 0; r < 2; r++) begin
            mode = 2'd1;
            pulse_start();
            mode  = 2'd0;
            ref_s = 32'hACE1_0000;
            acc   = 0;
            fin   = 1'b0;
            chk("t4_seed0", word(0), 64'hACE1_0000_ACE1_0000);
            chk("t4_seed3", word(3), 64'hACE1_0003_ACE1_0003);
            for (int s = 0; s < 1000 && !fin; s++) begin
                if (acc == 128) begin
                    chk("t4_ch0_done", 64'(ch_done[0]), 64'h1);
                    fin = 1'b1;
                end else begin
                    chk("t4_valid0", 64'(axis_tvalid[0]), 64'h1);
                    chk("t4_data0", word(0), {ref_s, ref_s});
                    chk("t4_last0", 64'(axis_tlast[0]), 64'((acc % 16) == 15));
                    axis_tready[0] = 1'($urandom_range(0, 1));
                    if (axis_tvalid[0] && axis_tready[0]) begin
                        acc++;
                        ref_s = lfsr_step(ref_s);
                    end
                    step();
                end
            end
            chk("t4_finished", 64'(fin), 64'h1);
        end
        axis_tready = '1;

        // ---------------- 5: reset mid-packet ----------------
        mode = 2'd0;
        pulse_start();
        repeat (7) step();
        chk("t5_beat7", word(3), cnt_word(8'h03, 8'h00, 16'h0007));
        #2 rst = 1'b0;
        #1;
        chk("t5_tvalid", 64'(axis_tvalid), 64'h0);
        chk("t5_tdata3", word(3), 64'h0);
        chk("t5_ch_done", 64'(ch_done), 64'h0);
        chk("t5_all_done", 64'(all_done), 64'h0);
        chk("t5_busy", 64'(busy), 64'h0);
        #2 rst = 1'b1;
        repeat (3) step();
        chk("t5_after_valid", 64'(axis_tvalid), 64'h0);
        chk("t5_after_done", 64'(ch_done), 64'h0);

        // ---------------- 6: restart; start while busy is ignored ----------------
        pulse_start();
        for (int b = 0; b < 128; b++) begin
            chk("t6_valid3", 64'(axis_tvalid[3]), 64'h1);
            chk("t6_data3", word(3), cnt_word(8'h03, 8'(b / 16), 16'(b % 16)));
            if (b == 5 || b == 127) start = 1'b1;
            step();
            start = 1'b0;
        end
        chk("t6_all_done", 64'(all_done), 64'h1);
        chk("t6_ch_done", 64'(ch_done), 64'hF);
        chk("t6_no_rerun", 64'(axis_tvalid), 64'h0);
        step();
        chk("t6_still_done", 64'(all_done), 64'h1);
        chk("t6_still_idle", 64'(axis_tvalid), 64'h0);
        chk("t6_not_busy", 64'(busy), 64'h0);
        pulse_start();
        chk("t6_rerun_done_clr", 64'(ch_done), 64'h0);
        chk("t6_rerun_alldone", 64'(all_done), 64'h0);
        chk("t6_rerun_valid", 64'(axis_tvalid), 64'hF);
        chk("t6_rerun_busy", 64'(busy), 64'h1);
        chk("t6_rerun_beat0", word(3), 64'h0300_0000_0300_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
